// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//   Receive-side rate decoder for the SNN output layer. After a start pulse it
//   counts spikes per output-neuron channel over a fixed window of WINDOW
//   cycles, using saturating counters. It then scans the counts one channel per
//   cycle to find the argmax and holds the result behind a valid/ready
//   handshake.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset (priority over all inputs)
//   start      : begin a decode window (honoured only while idle)
//   spike_in   : one spike bit per channel, sampled during the count phase
//   busy       : high whenever a decode is in progress or a result is pending
//   count_out  : per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   class_out  : index of the channel with the highest count (ties -> lowest)
//   no_spike   : every channel count was zero in the completed window
//   out_valid  : result available
//   out_ready  : downstream accepts the result
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
  parameter int N_CH   = 3,
  parameter int WINDOW = 255,
  parameter int CNT_W  = 8,
  parameter int CLS_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_CH-1:0]         spike_in,
  output logic                    busy,
  output logic [N_CH*CNT_W-1:0]   count_out,
  output logic [CLS_W-1:0]        class_out,
  output logic                    no_spike,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int IDX_W = $clog2(N_CH);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [WIN_W-1:0]   win_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   best_val_q;
  logic [CLS_W-1:0]   best_idx_q;
  logic [CLS_W-1:0]   class_q;
  logic               no_spike_q;
  logic               valid_q;
  logic               busy_q;

  logic [CNT_W-1:0]   cur_val_s;
  logic               take_s;
  logic [CNT_W-1:0]   new_val_s;
  logic [CLS_W-1:0]   new_idx_s;

  // Saturating next-count per channel: stick at all-ones instead of wrapping.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (spike_in[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Argmax step for the channel under scan; strict compare keeps the lowest
  // index on ties.
  always_comb begin
    cur_val_s = cnt_q[idx_q];
    take_s    = (cur_val_s > best_val_q);
    new_val_s = best_val_q;
    new_idx_s = best_idx_q;
    if (take_s) begin
      new_val_s = cur_val_s;
      new_idx_s = CLS_W'(idx_q);
    end else begin
      new_val_s = best_val_q;
      new_idx_s = best_idx_q;
    end
  end

  // Decoder FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      win_q      <= '0;
      idx_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      no_spike_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_COUNT;
            busy_q     <= 1'b1;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            win_q      <= '0;
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            class_q    <= '0;
            no_spike_q <= 1'b0;
          end
        end
        S_COUNT: begin
          for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
          if (win_q == WIN_LAST) begin
            state_q    <= S_SCAN;
            win_q      <= '0;
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
          end else begin
            win_q <= win_q + WIN_W'(1);
          end
        end
        S_SCAN: begin
          best_val_q <= new_val_s;
          best_idx_q <= new_idx_s;
          if (idx_q == IDX_LAST) begin
            // Last channel: publish using the just-computed best so the
            // result is valid on the same edge that enters DONE.
            state_q    <= S_DONE;
            valid_q    <= 1'b1;
            class_q    <= new_idx_s;
            no_spike_q <= (new_val_s == '0);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Counters are held through IDLE, so the last result stays visible.
  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign count_out[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign busy      = busy_q;
  assign class_out = class_q;
  assign no_spike  = no_spike_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//   Directed bench for spike_rate_decoder. One instance uses default
//   parameters; a second uses WINDOW=300 to exercise counter saturation.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [2:0]  spike_in;
  logic        out_ready;
  logic        busy;
  logic [23:0] count_out;
  logic [1:0]  class_out;
  logic        no_spike;
  logic        out_valid;

  logic        s_start;
  logic [2:0]  s_spike;
  logic        s_ready;
  logic        s_busy;
  logic [23:0] s_count;
  logic [1:0]  s_class;
  logic        s_no_spike;
  logic        s_valid;

  int n_checks = 0;
  int n_errors = 0;
  int edges;

  spike_rate_decoder u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .spike_in  (spike_in),
    .busy      (busy),
    .count_out (count_out),
    .class_out (class_out),
    .no_spike  (no_spike),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  spike_rate_decoder #(.N_CH(3), .WINDOW(300), .CNT_W(8), .CLS_W(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .start     (s_start),
    .spike_in  (s_spike),
    .busy      (s_busy),
    .count_out (s_count),
    .class_out (s_class),
    .no_spike  (s_no_spike),
    .out_valid (s_valid),
    .out_ready (s_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Spike pattern per window cycle k (1-based); bit i = channel i.
  function automatic logic [2:0] pat(input int kind, input int k);
    logic [2:0] p;
    case (kind)
      0:       p = {1'b0, k[0], 1'b1};                      // 255 / 128 / 0
      2:       p = {(k <= 100), (k <= 100), (k <= 50)};     // 50 / 100 / 100
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  // Entered at a falling edge; start is asserted for exactly one edge (E0).
  task automatic run_window(input int kind);
    start = 1'b1;
    @(posedge clk);
    edges = 0;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      start    = 1'b0;
      spike_in = pat(kind, k);
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    spike_in = 3'b111;  // must be ignored outside the count phase
    while (!out_valid && edges < 1000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("latency", edges, 258);
  endtask

  task automatic check_result(input string tag, input logic [23:0] cnt,
                              input logic [1:0] cls, input logic ns);
    check_eq({tag, "_busy"},  busy,      1'b1);
    check_eq({tag, "_count"}, count_out, cnt);
    check_eq({tag, "_class"}, class_out, cls);
    check_eq({tag, "_nospk"}, no_spike,  ns);
  endtask

  // Entered at a falling edge; completes the handshake and checks held values.
  task automatic handshake(input string tag, input logic [23:0] cnt, input logic [1:0] cls);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_hs_valid"}, out_valid, 1'b0);
    check_eq({tag, "_hs_busy"},  busy,      1'b0);
    check_eq({tag, "_hs_count"}, count_out, cnt);
    check_eq({tag, "_hs_class"}, class_out, cls);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    spike_in  = 3'b000;
    out_ready = 1'b0;
    s_start   = 1'b0;
    s_spike   = 3'b000;
    s_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {busy, out_valid, class_out, no_spike, count_out}, 29'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);

    // Rate-coded pattern: ch0 every cycle, ch1 every other, ch2 silent.
    run_window(0);
    check_result("rate", {8'd0, 8'd128, 8'd255}, 2'd0, 1'b0);
    handshake("rate", {8'd0, 8'd128, 8'd255}, 2'd0);

    // Silent window.
    run_window(1);
    check_result("zero", 24'd0, 2'd0, 1'b1);
    handshake("zero", 24'd0, 2'd0);

    // Tie between ch1 and ch2, then backpressure with ignored starts.
    run_window(2);
    check_result("tie", {8'd100, 8'd100, 8'd50}, 2'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      check_eq("hold", {out_valid, busy, no_spike, class_out, count_out},
               {1'b1, 1'b1, 1'b0, 2'd1, 8'd100, 8'd100, 8'd50});
    end
    start = 1'b0;
    handshake("tie", {8'd100, 8'd100, 8'd50}, 2'd1);

    // Start in the very next cycle after the handshake.
    run_window(0);
    check_result("restart", {8'd0, 8'd128, 8'd255}, 2'd0, 1'b0);
    handshake("restart", {8'd0, 8'd128, 8'd255}, 2'd0);

    // Reset in the middle of a count window.
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start    = 1'b0;
      spike_in = 3'b111;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst", {busy, out_valid, class_out, no_spike, count_out}, 29'd0);
    run_window(2);
    check_result("postrst", {8'd100, 8'd100, 8'd50}, 2'd1, 1'b0);
    handshake("postrst", {8'd100, 8'd100, 8'd50}, 2'd1);

    // Saturation: 300-cycle window, ch2 always spiking.
    s_start = 1'b1;
    @(posedge clk);
    edges = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      s_start = 1'b0;
      s_spike = {1'b1, (k <= 10), (k <= 10)};
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    s_spike = 3'b000;
    while (!s_valid && edges < 1000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("sat_latency", edges, 303);
    check_eq("sat_count", s_count, {8'd255, 8'd10, 8'd10});
    check_eq("sat_class", s_class, 2'd2);
    check_eq("sat_nospk", s_no_spike, 1'b0);
    s_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_ready = 1'b0;
    check_eq("sat_hs_valid", s_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Rate decoder for the SNN output layer, the receive-side counterpart of the LFSR-based input rate encoder. It counts spikes per output-neuron channel over a fixed window of clock cycles, then sequentially scans the counts to pick the winning class (argmax). It presents the result through a valid/ready handshake to the downstream classification/readout logic.

Parameters:
N_CH, 3, number of spike channels (output neurons); legal range 2..16
WINDOW, 255, decode window length in cycles (spike samples per channel); must be >= 1
CNT_W, 8, width of each per-channel spike counter; counters saturate
CLS_W, 2, width of class_out; must satisfy 2^CLS_W >= N_CH

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a decode window; sampled only in IDLE
spike_in  input  N_CH  one spike bit per channel, sampled every COUNT cycle
busy  output  1  high in any state other than IDLE
count_out  output  N_CH*CNT_W  final per-channel counts; channel i at bits [i*CNT_W +: CNT_W]; valid while out_valid
class_out  output  CLS_W  index of the channel with the highest count
no_spike  output  1  all channel counts zero in the completed window
out_valid  output  1  result available
out_ready  input  1  downstream accepts result

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. Reset has priority over every other input.
- Reset values: state=IDLE; all counters, window counter and scan index = 0; busy=0, out_valid=0, class_out=0, no_spike=0, count_out=0.
- States: IDLE, COUNT, SCAN, DONE.
- IDLE to COUNT: on start=1 at edge E0. At that edge, clear all counters, window counter=0 and class registers.
- COUNT, edges E1..E_WINDOW: per channel, counter[i] <= counter[i] + spike_in[i]. Saturate at 2^CNT_W-1; no wrap.
  - The window counter increments once per edge.
  - At edge E_WINDOW (window counter == WINDOW-1), state goes to SCAN with scan index=0, best_val=0, best_idx=0.
  - spike_in is ignored in every state except COUNT.
- SCAN, one channel per edge (edges E_WINDOW+1..E_WINDOW+N_CH):
  - If counter[idx] > best_val (strictly greater), set best_val=counter[idx] and best_idx=idx.
  - Ties therefore resolve to the lowest index.
  - After idx=N_CH-1, go to DONE.
- DONE: out_valid=1. class_out=best_idx. no_spike=1 iff best_val==0; class_out is then 0.
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid=1 and out_ready=1, go to IDLE and clear out_valid. count_out, class_out and no_spike keep their last values until the next start.
- Latency: out_valid first visible after edge E_(WINDOW+N_CH). With defaults, that is 258 edges after the start edge.
- start outside IDLE is ignored; no queuing. A start in the cycle right after the handshake (IDLE) is accepted.
- Reset mid-window or mid-scan aborts immediately to reset values; no partial result is produced.
- Arithmetic is unsigned. The window counter is wide enough to hold WINDOW-1.
- busy=1 in COUNT, SCAN and DONE.

Test Plan:
- Defaults; ch0 spike every cycle, ch1 every 2nd cycle, ch2 never -> out_valid after 258 edges; counts 255/128/0 (ch1 starts high at E1), class_out=0, no_spike=0.
- spike_in=0 for the whole window -> counts all 0, class_out=0, no_spike=1.
- Tie: ch1 and ch2 both spike 100 times, ch0 50 times -> class_out=1.
- Saturation: WINDOW=300, CNT_W=8, ch2 always spiking, others 10 spikes -> ch2 count=255 (no wrap), class_out=2.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, busy=1. start pulses in that time are ignored. Raise out_ready -> IDLE next edge; a new start one cycle later is accepted.
- Reset asserted at cycle 100 of COUNT -> next cycle all outputs 0, state IDLE. A new full window then reports only its own spikes.
